// File: rtl/tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, IR/DR strobes, BYPASS register and TDO mux.
// Define TAP_IDCODE_EN to add the 32-bit IDCODE register; otherwise IDCODE_INSTR acts as BYPASS.
module tap_ctrl #(
  parameter int                       IR_DATA_WIDTH = 4,
  parameter logic [IR_DATA_WIDTH-1:0] BYPASS_INSTR  = '1,
  parameter logic [IR_DATA_WIDTH-1:0] IDCODE_INSTR  = {{(IR_DATA_WIDTH-1){1'b0}}, 1'b1},
  parameter logic [31:0]              IDCODE_VALUE  = 32'h1000_00F1
) (
  input  logic                     TCK,
  input  logic                     TRST,
  input  logic                     TMS,
  input  logic                     TDI,
  input  logic [IR_DATA_WIDTH-1:0] LATCH_IR,
  input  logic                     I_TDO_IR,
  input  logic                     TDO_DR_EXT,
  output logic                     TLR,
  output logic                     CAPTURE_IR,
  output logic                     SHIFT_IR,
  output logic                     UPDATE_IR,
  output logic                     CAPTURE_DR,
  output logic                     SHIFT_DR,
  output logic                     UPDATE_DR,
  output logic                     SEL_USER,
  output logic [3:0]               STATE,
  output logic                     TDO,
  output logic                     TDO_EN
);

  typedef enum logic [3:0] {
    S_EX2DR = 4'h0, S_EX1DR = 4'h1, S_SHDR  = 4'h2, S_PAUDR = 4'h3,
    S_SELIR = 4'h4, S_UPDDR = 4'h5, S_CAPDR = 4'h6, S_SELDR = 4'h7,
    S_EX2IR = 4'h8, S_EX1IR = 4'h9, S_SHIR  = 4'hA, S_PAUIR = 4'hB,
    S_RTI   = 4'hC, S_UPDIR = 4'hD, S_CAPIR = 4'hE, S_TLR   = 4'hF
  } state_t;

  // IDCODE bit 0 is the mandatory 1 marker that distinguishes IDCODE from BYPASS on a chain.
  if (IDCODE_VALUE[0] != 1'b1) begin : g_bad_idcode
    $error("IDCODE_VALUE bit 0 must be 1");
  end

  state_t r_state;
  state_t w_next;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) r_state <= S_TLR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    TLR        = 1'b0;
    CAPTURE_IR = 1'b0;
    SHIFT_IR   = 1'b0;
    UPDATE_IR  = 1'b0;
    CAPTURE_DR = 1'b0;
    SHIFT_DR   = 1'b0;
    UPDATE_DR  = 1'b0;
    case (r_state)
      S_TLR:   begin w_next = TMS ? S_TLR   : S_RTI;   TLR = 1'b1; end
      S_RTI:         w_next = TMS ? S_SELDR : S_RTI;
      S_SELDR:       w_next = TMS ? S_SELIR : S_CAPDR;
      S_CAPDR: begin w_next = TMS ? S_EX1DR : S_SHDR;  CAPTURE_DR = 1'b1; end
      S_SHDR:  begin w_next = TMS ? S_EX1DR : S_SHDR;  SHIFT_DR   = 1'b1; end
      S_EX1DR:       w_next = TMS ? S_UPDDR : S_PAUDR;
      S_PAUDR:       w_next = TMS ? S_EX2DR : S_PAUDR;
      S_EX2DR:       w_next = TMS ? S_UPDDR : S_SHDR;
      S_UPDDR: begin w_next = TMS ? S_SELDR : S_RTI;   UPDATE_DR  = 1'b1; end
      S_SELIR:       w_next = TMS ? S_TLR   : S_CAPIR;
      S_CAPIR: begin w_next = TMS ? S_EX1IR : S_SHIR;  CAPTURE_IR = 1'b1; end
      S_SHIR:  begin w_next = TMS ? S_EX1IR : S_SHIR;  SHIFT_IR   = 1'b1; end
      S_EX1IR:       w_next = TMS ? S_UPDIR : S_PAUIR;
      S_PAUIR:       w_next = TMS ? S_EX2IR : S_PAUIR;
      S_EX2IR:       w_next = TMS ? S_UPDIR : S_SHIR;
      S_UPDIR: begin w_next = TMS ? S_SELDR : S_RTI;   UPDATE_IR  = 1'b1; end
      default:       w_next = S_TLR;
    endcase
  end

  assign STATE = r_state;

  logic w_sel_id;
  logic w_sel_byp;
  logic w_id_bit;

  // SEL_USER ignores the build option so user logic sees the same decode either way.
  assign SEL_USER  = (LATCH_IR != BYPASS_INSTR) && (LATCH_IR != IDCODE_INSTR);
  assign w_sel_byp = !SEL_USER && !w_sel_id;

  logic r_bypass;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST)                              r_bypass <= 1'b0;
    else if (r_state == S_CAPDR)            r_bypass <= 1'b0;
    else if (r_state == S_SHDR && w_sel_byp) r_bypass <= TDI;
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] r_idcode;

  assign w_sel_id = (LATCH_IR == IDCODE_INSTR);
  assign w_id_bit = r_idcode[0];

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST)                              r_idcode <= IDCODE_VALUE;
    else if (r_state == S_CAPDR)            r_idcode <= IDCODE_VALUE;
    else if (r_state == S_SHDR && w_sel_id) r_idcode <= {TDI, r_idcode[31:1]};
  end
`else
  assign w_sel_id = 1'b0;
  assign w_id_bit = 1'b0;
`endif

  logic w_dr_bit;
  assign w_dr_bit = SEL_USER ? TDO_DR_EXT : (w_sel_id ? w_id_bit : r_bypass);

  logic r_tdo_en;
  logic r_tdo_ir_sel;
  logic r_tdo_dr;

  // Retime on the falling edge so TDO is stable around the next rising edge at the far end.
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_tdo_en     <= 1'b0;
      r_tdo_ir_sel <= 1'b0;
      r_tdo_dr     <= 1'b0;
    end else begin
      r_tdo_en     <= (r_state == S_SHIR) || (r_state == S_SHDR);
      r_tdo_ir_sel <= (r_state == S_SHIR);
      r_tdo_dr     <= w_dr_bit;
    end
  end

  assign TDO_EN = r_tdo_en;
  assign TDO    = r_tdo_en && (r_tdo_ir_sel ? I_TDO_IR : r_tdo_dr);

endmodule

// File: tb/tb_tap_ctrl.sv
// Self-checking bench for tap_ctrl: table-driven TAP model, small `ir` stand-in, scan scoreboards.
module tb_tap_ctrl;

  localparam logic [31:0] IDCODE = 32'h1000_00F1;

  logic       TCK = 1'b0;
  logic       TRST = 1'b0;
  logic       TMS = 1'b1;
  logic       TDI = 1'b0;
  logic       TDO_DR_EXT = 1'b0;
  logic [3:0] LATCH_IR;
  logic       I_TDO_IR;
  logic       TLR, CAPTURE_IR, SHIFT_IR, UPDATE_IR, CAPTURE_DR, SHIFT_DR, UPDATE_DR;
  logic       SEL_USER, TDO, TDO_EN;
  logic [3:0] STATE;

  tap_ctrl dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
    .LATCH_IR(LATCH_IR), .I_TDO_IR(I_TDO_IR), .TDO_DR_EXT(TDO_DR_EXT),
    .TLR(TLR), .CAPTURE_IR(CAPTURE_IR), .SHIFT_IR(SHIFT_IR), .UPDATE_IR(UPDATE_IR),
    .CAPTURE_DR(CAPTURE_DR), .SHIFT_DR(SHIFT_DR), .UPDATE_DR(UPDATE_DR),
    .SEL_USER(SEL_USER), .STATE(STATE), .TDO(TDO), .TDO_EN(TDO_EN)
  );

  always #5 TCK = ~TCK;

  // Stand-in for the `ir` instance: captures 4'b0101, update on negedge, retimed serial out.
  logic [3:0] ir_sr = 4'b0000;
  always @(posedge TCK) begin
    if (CAPTURE_IR)    ir_sr <= 4'b0101;
    else if (SHIFT_IR) ir_sr <= {TDI, ir_sr[3:1]};
  end
  always @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      LATCH_IR <= 4'hF;
      I_TDO_IR <= 1'b0;
    end else begin
      if (TLR)            LATCH_IR <= 4'hF;
      else if (UPDATE_IR) LATCH_IR <= ir_sr;
      I_TDO_IR <= ir_sr[0];
    end
  end

  // Reference model: next-state tables filled straight from the transition list.
  logic [3:0] nx0 [16];
  logic [3:0] nx1 [16];
  logic [3:0] m_state;
  int n_vec = 0;
  int n_err = 0;

  wire [6:0] strobes = {TLR, CAPTURE_IR, SHIFT_IR, UPDATE_IR, CAPTURE_DR, SHIFT_DR, UPDATE_DR};

  task automatic fill_tables();
    // DR column
    nx0[4'hF] = 4'hC; nx1[4'hF] = 4'hF;
    nx0[4'hC] = 4'hC; nx1[4'hC] = 4'h7;
    nx0[4'h7] = 4'h6; nx1[4'h7] = 4'h4;
    nx0[4'h6] = 4'h2; nx1[4'h6] = 4'h1;
    nx0[4'h2] = 4'h2; nx1[4'h2] = 4'h1;
    nx0[4'h1] = 4'h3; nx1[4'h1] = 4'h5;
    nx0[4'h3] = 4'h3; nx1[4'h3] = 4'h0;
    nx0[4'h0] = 4'h2; nx1[4'h0] = 4'h5;
    nx0[4'h5] = 4'hC; nx1[4'h5] = 4'h7;
    // IR column
    nx0[4'h4] = 4'hE; nx1[4'h4] = 4'hF;
    nx0[4'hE] = 4'hA; nx1[4'hE] = 4'h9;
    nx0[4'hA] = 4'hA; nx1[4'hA] = 4'h9;
    nx0[4'h9] = 4'hB; nx1[4'h9] = 4'hD;
    nx0[4'hB] = 4'hB; nx1[4'hB] = 4'h8;
    nx0[4'h8] = 4'hA; nx1[4'h8] = 4'hD;
    nx0[4'hD] = 4'hC; nx1[4'hD] = 4'h7;
  endtask

  function automatic logic [6:0] exp_strobes(input logic [3:0] s);
    return {s == 4'hF, s == 4'hE, s == 4'hA, s == 4'hD, s == 4'h6, s == 4'h2, s == 4'h5};
  endfunction

  // Entered and left just after a falling edge; outputs are then settled for sampling.
  task automatic step(input logic tms, input logic tdi, input logic ext);
    TMS = tms;
    TDI = tdi;
    TDO_DR_EXT = ext;
    @(posedge TCK);
    m_state = tms ? nx1[m_state] : nx0[m_state];
    @(negedge TCK);
    #1;
  endtask

  task automatic ir_scan(input logic [3:0] op, output logic [3:0] q, output logic [1:0] upd);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    q[0] = TDO;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, op[i], 1'b0);
      if (i < 3) q[i+1] = TDO;
    end
    step(1'b1, 1'b0, 1'b0);
    upd[0] = UPDATE_IR;
    step(1'b0, 1'b0, 1'b0);
    upd[1] = UPDATE_IR;
  endtask

  task automatic dr_scan(input int n, input logic [63:0] d, input logic [63:0] ext,
                         output logic [63:0] q);
    q = '0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, ext[0]);
    q[0] = TDO;
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, d[i], (i + 1 < n) ? ext[i+1] : 1'b0);
      if (i < n - 1) q[i+1] = TDO;
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] mask_of(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  task automatic test_reset();
    #12;
    n_vec++;
    if (STATE !== 4'hF) begin n_err++; $display("FAIL reset_state: got %h want f", STATE); end
    n_vec++;
    if (strobes !== 7'b1000000) begin n_err++; $display("FAIL reset_strobes: got %b want 1000000", strobes); end
    n_vec++;
    if (TDO !== 1'b0 || TDO_EN !== 1'b0) begin
      n_err++; $display("FAIL reset_tdo: got tdo=%b en=%b want 0 0", TDO, TDO_EN);
    end
    @(negedge TCK);
    #1;
    TRST = 1'b1;
    m_state = 4'hF;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_fsm_random();
    logic en_exp;
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      en_exp = (m_state == 4'hA) || (m_state == 4'h2);
      n_vec++;
      if (STATE !== m_state) begin n_err++; $display("FAIL fsm_state step %0d: got %h want %h", k, STATE, m_state); end
      n_vec++;
      if (strobes !== exp_strobes(m_state)) begin
        n_err++; $display("FAIL fsm_strobes step %0d: got %b want %b", k, strobes, exp_strobes(m_state));
      end
      n_vec++;
      if (TDO_EN !== en_exp) begin n_err++; $display("FAIL fsm_tdo_en step %0d: got %b want %b", k, TDO_EN, en_exp); end
      if (!en_exp) begin
        n_vec++;
        if (TDO !== 1'b0) begin n_err++; $display("FAIL fsm_tdo_idle step %0d: got %b want 0", k, TDO); end
      end
    end
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_five_ones();
    int len;
    for (int t = 0; t < 20; t++) begin
      len = $urandom_range(0, 20);
      for (int k = 0; k < len; k++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
      n_vec++;
      if (STATE !== 4'hF) begin n_err++; $display("FAIL five_ones trial %0d: got %h want f", t, STATE); end
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ir_scan();
    logic [3:0] q;
    logic [1:0] upd;
    ir_scan(4'h1, q, upd);
    n_vec++;
    if (q !== 4'b0101) begin n_err++; $display("FAIL ir_capture_tdo: got %b want 0101 (lsb first)", q); end
    n_vec++;
    if (upd !== 2'b01) begin n_err++; $display("FAIL ir_update_pulse: got %b want 01", upd); end
    n_vec++;
    if (SEL_USER !== 1'b0) begin n_err++; $display("FAIL ir_sel_user: got %b want 0", SEL_USER); end
  endtask

  task automatic test_bypass();
    logic [3:0]  qi;
    logic [1:0]  upd;
    logic [63:0] q;
    logic [63:0] d;
    int n;
    ir_scan(4'hF, qi, upd);
    n_vec++;
    if (SEL_USER !== 1'b0) begin n_err++; $display("FAIL byp_sel_user: got %b want 0", SEL_USER); end
    dr_scan(8, 64'hA5, 64'h0, q);
    n_vec++;
    if (q[7:0] !== 8'h4A) begin n_err++; $display("FAIL byp_a5: got %h want 4a", q[7:0]); end
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 40);
      d = {$urandom, $urandom};
      dr_scan(n, d, 64'h0, q);
      n_vec++;
      if ((q & mask_of(n)) !== ((d << 1) & mask_of(n))) begin
        n_err++; $display("FAIL byp_rand n=%0d: got %h want %h", n, q & mask_of(n), (d << 1) & mask_of(n));
      end
    end
  endtask

  task automatic test_idcode();
    logic [3:0]  qi;
    logic [1:0]  upd;
    logic [63:0] q;
    logic [63:0] d;
    logic [63:0] exp;
    ir_scan(4'h1, qi, upd);
    n_vec++;
    if (SEL_USER !== 1'b0) begin n_err++; $display("FAIL id_sel_user: got %b want 0", SEL_USER); end
    for (int t = 0; t < 3; t++) begin
      d = {$urandom, $urandom};
`ifdef TAP_IDCODE_EN
      exp = ((d << 32) | {32'h0, IDCODE}) & mask_of(48);
`else
      exp = (d << 1) & mask_of(48);
`endif
      dr_scan(48, d, 64'h0, q);
      n_vec++;
      if ((q & mask_of(48)) !== exp) begin
        n_err++; $display("FAIL idcode_scan %0d: got %h want %h", t, q & mask_of(48), exp);
      end
    end
  endtask

  task automatic test_user();
    logic [3:0]  qi;
    logic [1:0]  upd;
    logic [3:0]  op;
    logic [63:0] q;
    logic [63:0] ext;
    int n;
    for (int t = 0; t < 4; t++) begin
      op = 4'($urandom_range(2, 14));
      ir_scan(op, qi, upd);
      n_vec++;
      if (SEL_USER !== 1'b1) begin n_err++; $display("FAIL user_sel op=%h: got %b want 1", op, SEL_USER); end
      n = $urandom_range(1, 40);
      ext = {$urandom, $urandom};
      dr_scan(n, {$urandom, $urandom}, ext, q);
      n_vec++;
      if ((q & mask_of(n)) !== (ext & mask_of(n))) begin
        n_err++; $display("FAIL user_tdo n=%0d: got %h want %h", n, q & mask_of(n), ext & mask_of(n));
      end
    end
  endtask

  task automatic test_trst_abort();
    logic [3:0] qi;
    logic [1:0] upd;
    ir_scan(4'hF, qi, upd);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    TMS = 1'b1;
    TRST = 1'b0;
    #1;
    m_state = 4'hF;
    n_vec++;
    if (STATE !== 4'hF || TLR !== 1'b1) begin
      n_err++; $display("FAIL trst_state: got state=%h tlr=%b want f 1", STATE, TLR);
    end
    n_vec++;
    if (TDO_EN !== 1'b0 || TDO !== 1'b0) begin
      n_err++; $display("FAIL trst_tdo: got en=%b tdo=%b want 0 0", TDO_EN, TDO);
    end
    TRST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0);
      n_vec++;
      if (UPDATE_DR !== 1'b0 || STATE !== 4'hF) begin
        n_err++; $display("FAIL trst_no_update %0d: got upd=%b state=%h want 0 f", k, UPDATE_DR, STATE);
      end
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    fill_tables();
    test_reset();
    test_fsm_random();
    test_five_ones();
    test_ir_scan();
    test_bypass();
    test_idcode();
    test_user();
    test_trst_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete within 400000 time units");
    $fatal(1);
  end

endmodule
